// File: rtl/eos_slot_sched_if.sv
// Request/grant handshake between the EOS metadata queues, the slot scheduler and the EBM.
interface eos_slot_sched_if #(
  parameter int unsigned LEN_W = 11
);
  logic [3:0]         q_req;
  logic [4*LEN_W-1:0] q_len;
  logic               tx_done;
  logic [3:0]         grant;
  logic               grant_wr;

  modport master (input q_req, q_len, tx_done, output grant, grant_wr);
  modport slave  (output q_req, q_len, tx_done, input grant, grant_wr);
endinterface

// File: rtl/eos_slot_sched.sv
// CQF slot timebase plus head-of-line dispatch scheduler: one grant at a time,
// only when the head packet fits in the time left in the current slot.
module eos_slot_sched #(
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_cfg_enable,
  input  logic [31:0]      in_cfg_slot_len,
  input  logic [15:0]      in_cfg_guard_len,
  input  logic             in_sync,
  eos_slot_sched_if.master bus,
  output logic             out_time_slot_flag,
  output logic [15:0]      out_slot_id,
  output logic             out_guard,
  output logic [31:0]      out_grant_cnt,
  output logic [31:0]      out_fit_block_cnt
);
  localparam int unsigned NQ    = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ID_W  = 16;
  localparam int unsigned CYC_W = 8;
  localparam logic [CNT_W-1:0] MIN_SLOT = CNT_W'(16);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] slot_cnt, slot_len_q, slot_len_clamp, remaining;
  logic             slot_end;
  logic [NQ-1:0]    elig, grantable, pick;
  logic [NQ-1:0]    grant_nxt;
  logic             grant_wr_nxt;
  logic [31:0]      grant_cnt_nxt, fit_block_nxt;

  // Transfer cycles on the 8-byte datapath, rounded up.
  function automatic logic [CYC_W-1:0] len_to_cycles(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(7);
    return CYC_W'(sum >> 3);
  endfunction

  assign slot_len_clamp = (in_cfg_slot_len < MIN_SLOT) ? MIN_SLOT : in_cfg_slot_len;
  assign remaining      = slot_len_q - CNT_W'(1) - slot_cnt;
  assign slot_end       = (slot_cnt == slot_len_q - CNT_W'(1));

  // Timebase: sync wins over the boundary; disable freezes the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt           <= '0;
      slot_len_q         <= MIN_SLOT;
      out_time_slot_flag <= 1'b0;
      out_slot_id        <= '0;
      out_guard          <= 1'b0;
    end else begin
      out_guard <= (remaining < CNT_W'(in_cfg_guard_len));
      if (in_sync) begin
        slot_cnt           <= '0;
        slot_len_q         <= slot_len_clamp;
        out_time_slot_flag <= 1'b0;
        out_slot_id        <= '0;
      end else if (in_cfg_enable) begin
        if (slot_end) begin
          slot_cnt           <= '0;
          slot_len_q         <= slot_len_clamp;
          out_time_slot_flag <= ~out_time_slot_flag;
          out_slot_id        <= out_slot_id + ID_W'(1);
        end else begin
          slot_cnt <= slot_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Only the CQF queue matching the current slot parity may be served.
  always_comb begin
    elig      = bus.q_req & {1'b1, 1'b1, ~out_time_slot_flag, out_time_slot_flag};
    grantable = '0;
    pick      = '0;
    for (int i = 0; i < NQ; i++) begin
      grantable[i] = elig[i] &&
                     (CNT_W'(len_to_cycles(bus.q_len[i*LEN_W +: LEN_W])) <= remaining);
    end
    for (int i = NQ - 1; i >= 0; i--) begin
      if (grantable[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = bus.grant;
    grant_wr_nxt  = 1'b0;
    grant_cnt_nxt = out_grant_cnt;
    fit_block_nxt = out_fit_block_cnt;
    case (state)
      ST_IDLE: begin
        if (in_cfg_enable && (|grantable)) begin
          grant_nxt     = pick;
          grant_wr_nxt  = 1'b1;
          grant_cnt_nxt = out_grant_cnt + 32'(1);
          state_nxt     = ST_GRANT;
        end else if (|elig) begin
          fit_block_nxt = out_fit_block_cnt + 32'(1);
        end
      end
      ST_GRANT: begin
        if (bus.tx_done) begin
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.tx_done) begin
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      bus.grant         <= '0;
      bus.grant_wr      <= 1'b0;
      out_grant_cnt     <= '0;
      out_fit_block_cnt <= '0;
    end else begin
      state             <= state_nxt;
      bus.grant         <= grant_nxt;
      bus.grant_wr      <= grant_wr_nxt;
      out_grant_cnt     <= grant_cnt_nxt;
      out_fit_block_cnt <= fit_block_nxt;
    end
  end

endmodule

// File: tb/tb_eos_slot_sched.sv
// Directed bench for eos_slot_sched: grant scoreboard plus timebase, fit and reset checks.
module tb_eos_slot_sched;
  localparam int unsigned LEN_W = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] slot_len;
  logic [15:0] guard_len;
  logic        sync;
  logic        flag;
  logic [15:0] slot_id;
  logic        guard;
  logic [31:0] gcnt;
  logic [31:0] fbcnt;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  eos_slot_sched_if #(.LEN_W(LEN_W)) bus ();

  eos_slot_sched #(.LEN_W(LEN_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_cfg_enable     (en),
    .in_cfg_slot_len   (slot_len),
    .in_cfg_guard_len  (guard_len),
    .in_sync           (sync),
    .bus               (bus),
    .out_time_slot_flag(flag),
    .out_slot_id       (slot_id),
    .out_guard         (guard),
    .out_grant_cnt     (gcnt),
    .out_fit_block_cnt (fbcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sync(input logic [31:0] len);
    slot_len = len;
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic set_len(input int q, input int len);
    bus.q_len[q*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!bus.grant_wr && n < 300) begin
      tick();
      n++;
    end
    if (!bus.grant_wr) check("grant_timeout", 32'(bus.grant_wr), 32'd1);
  endtask

  // Hold the grant d cycles, then signal done and retire the served request.
  task automatic finish_grant(input int d);
    repeat (d) tick();
    bus.tx_done = 1'b1;
    bus.q_req   = bus.q_req & ~bus.grant;
    tick();
    bus.tx_done = 1'b0;
    check("grant_clr", 32'(bus.grant), 32'd0);
  endtask

  task automatic wait_toggle(output int n);
    logic f0;
    f0 = flag;
    n = 0;
    do begin
      tick();
      n++;
    end while (flag == f0 && n < 1000);
    if (flag == f0) check("toggle_timeout", 32'(flag), 32'(!f0));
  endtask

  // Scoreboard: every grant pulse must match the next expected one-hot grant.
  always @(negedge clk) begin
    if (!rst && bus.grant_wr) begin
      if (exp_q.size() == 0) check("grant_unexp", 32'(bus.grant), 32'd0);
      else                   check("grant", 32'(bus.grant), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; slot_len = 32'd100; guard_len = 16'd4; sync = 1'b0;
    bus.q_req = '0; bus.q_len = '0; bus.tx_done = 1'b0;
    repeat (3) tick();
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_id", 32'(slot_id), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_wr", 32'(bus.grant_wr), 32'd0);
    check("rst_gcnt", gcnt, 32'd0);
    check("rst_fbcnt", fbcnt, 32'd0);
    rst = 1'b0; en = 1'b1;

    // Timebase period, id sequence and clamping of a short slot
    do_sync(32'd100);
    check("sync_id", 32'(slot_id), 32'd0);
    wait_toggle(n); check("period0", 32'(n), 32'd100); check("id1", 32'(slot_id), 32'd1);
    slot_len = 32'd5;
    wait_toggle(n); check("period1", 32'(n), 32'd100); check("id2", 32'(slot_id), 32'd2);
    wait_toggle(n); check("period_clamp", 32'(n), 32'd16); check("id3", 32'(slot_id), 32'd3);

    // Guard lags slot_cnt by one cycle
    do_sync(32'd100);
    repeat (96) tick();
    check("guard_lo", 32'(guard), 32'd0);
    tick();
    check("guard_hi", 32'(guard), 32'd1);

    // Disabled: timebase frozen, no grants
    do_sync(32'd100);
    en = 1'b0;
    set_len(2, 64);
    bus.q_req = 4'b0100;
    repeat (150) tick();
    check("dis_grant", 32'(bus.grant), 32'd0);
    check("dis_flag", 32'(flag), 32'd0);
    check("dis_id", 32'(slot_id), 32'd0);
    exp_q.push_back(4'b0100);
    en = 1'b1;
    wait_grant(n); check("dis_lat", 32'(n), 32'd1);
    finish_grant(0);

    // CQF ping-pong
    do_sync(32'd100);
    set_len(0, 64); set_len(1, 64);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
    bus.q_req = 4'b0011;
    wait_grant(n); check("pp_lat", 32'(n), 32'd1);
    finish_grant(0);
    wait_grant(n);
    check("pp_flag", 32'(flag), 32'd1);
    finish_grant(0);

    // Priority order and tx_done-to-grant spacing
    do_sync(32'd100);
    set_len(1, 64); set_len(2, 64); set_len(3, 64);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    bus.q_req = 4'b1110;
    wait_grant(n);
    finish_grant(3);
    wait_grant(n); check("prio_gap1", 32'(n), 32'd1);
    finish_grant(2);
    wait_grant(n); check("prio_gap2", 32'(n), 32'd1);
    finish_grant(1);
    check("prio_gcnt", gcnt, 32'd6);

    // Reset while BUSY
    set_len(2, 64);
    exp_q.push_back(4'b0100);
    bus.q_req = 4'b0100;
    wait_grant(n);
    repeat (2) tick();
    rst = 1'b1;
    bus.q_req = '0;
    tick();
    check("rb_grant", 32'(bus.grant), 32'd0);
    check("rb_wr", 32'(bus.grant_wr), 32'd0);
    check("rb_gcnt", gcnt, 32'd0);
    check("rb_fbcnt", fbcnt, 32'd0);
    check("rb_flag", 32'(flag), 32'd0);
    check("rb_id", 32'(slot_id), 32'd0);
    rst = 1'b0;
    exp_q.push_back(4'b0100);
    bus.q_req = 4'b0100;
    wait_grant(n); check("rb_idle_lat", 32'(n), 32'd1);
    finish_grant(0);
    check("rb_gcnt1", gcnt, 32'd1);

    // Fit: q3 passes blocked q2; q2 waits for the next slot
    do_sync(32'd100);
    repeat (89) tick();
    set_len(2, 200); set_len(3, 64);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0100);
    bus.q_req = 4'b1100;
    wait_grant(n); check("fit_lat", 32'(n), 32'd1);
    finish_grant(0);
    wait_grant(n);
    check("fit_block", fbcnt, 32'd9);
    check("fit_flag", 32'(flag), 32'd1);
    check("fit_id", 32'(slot_id), 32'd1);
    finish_grant(0);
    check("fit_gcnt", gcnt, 32'd3);

    // Sync on the boundary cycle; BUSY grant untouched
    do_sync(32'd20);
    set_len(2, 64);
    exp_q.push_back(4'b0100);
    bus.q_req = 4'b0100;
    wait_grant(n);
    repeat (18) tick();
    do_sync(32'd20);
    check("col_flag", 32'(flag), 32'd0);
    check("col_id", 32'(slot_id), 32'd0);
    check("col_hold", 32'(bus.grant), 32'd4);
    wait_toggle(n); check("col_period", 32'(n), 32'd20);
    check("col_hold2", 32'(bus.grant), 32'd4);
    finish_grant(0);

    tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
